traffic_checker: RTL and testbench

- AXI Stream sink that sits directly downstream of the traffic generator (`tg`) and consumes its stream.
- Verifies framing, TKEEP and payload against the same runtime configuration words the generator uses, counts received flits and packets, and accumulates per-class error counters.
- Optionally applies pseudo-random backpressure on TREADY.
- Pipelined so that all per-beat checks close timing at 322 MHz for WIDTH=512.

---
 rtl/traffic_checker_if.sv | 11 +
 rtl/traffic_checker.sv | 183 ++++++++++++++++++
 tb/tb_traffic_checker.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/traffic_checker_if.sv
// AXI Stream link between the traffic generator and the traffic checker.
interface traffic_checker_if #(parameter int WIDTH = 512);
  logic [WIDTH-1:0]   TDATA;
  logic [WIDTH/8-1:0] TKEEP;
  logic               TVALID;
  logic               TREADY;
  logic               TLAST;

  modport master (output TDATA, TKEEP, TVALID, TLAST, input TREADY);
  modport slave  (input TDATA, TKEEP, TVALID, TLAST, output TREADY);
endinterface

// File: rtl/traffic_checker.sv
// AXI Stream sink: checks framing, TKEEP and payload of the generator stream,
// counts flits/packets and keeps saturating per-class error counters.

// One 32-bit word of the beat: expected keep and fill-pattern payload check.
module traffic_checker_lane #(
  parameter int LANE  = 0,
  parameter int BYTES = 64
) (
  input  logic [31:0] word,
  input  logic [3:0]  keep,
  input  logic        last,
  input  logic [7:0]  lfb,
  input  logic [1:0]  fill,
  output logic        data_bad,
  output logic        keep_bad
);
  localparam logic [31:0] PATTERN = 32'hDEADBEEF;

  logic [3:0] exp_keep;
  logic [3:0] byte_bad;

  always_comb begin
    exp_keep = '0;
    byte_bad = '0;
    for (int b = 0; b < 4; b++) begin
      // byte position counted from the top of the bus must fall inside last_flit_bytes
      exp_keep[b] = !last || (32'(BYTES - 1 - (4 * LANE + b)) < {24'd0, lfb});
      case (fill)
        2'b00:   byte_bad[b] = keep[b] && (word[8*b +: 8] != 8'h00);
        2'b11:   byte_bad[b] = keep[b] && (word[8*b +: 8] != PATTERN[8*b +: 8]);
        default: byte_bad[b] = 1'b0;
      endcase
    end
  end

  assign data_bad = |byte_bad;
  assign keep_bad = (keep != exp_keep);
endmodule

module traffic_checker #(
  parameter int WIDTH = 512
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mode,
  input  logic [31:0] num_packets,
  input  logic [31:0] num_flits,
  input  logic [31:0] last_flit_bytes,
  traffic_checker_if.slave axis,
  output logic [31:0] flits_rx,
  output logic [31:0] packets_rx,
  output logic [15:0] err_last,
  output logic [15:0] err_keep,
  output logic [15:0] err_data,
  output logic [15:0] err_hdr,
  output logic        err_any,
  output logic        done
);
  localparam int BYTES     = WIDTH / 8;
  localparam int NUM_LANES = WIDTH / 32;
  localparam int STAGES    = 0;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic        en, loop, bp_en;
  logic [1:0]  fill;
  logic [15:0] np, nf;
  logic [7:0]  lfb;
  logic        unused_cfg;

  assign en    = mode[0];
  assign fill  = mode[2:1];
  assign loop  = mode[3];
  assign bp_en = mode[4];
  assign np    = num_packets[15:0];
  assign nf    = num_flits[15:0];
  assign lfb   = last_flit_bytes[7:0];
  assign unused_cfg = ^{mode[31:5], num_packets[31:16], num_flits[31:16], last_flit_bytes[31:8]};

  logic [1:0]  state, state_nxt;
  logic        tready_q;
  logic [15:0] lfsr;
  logic [15:0] exp_flit, exp_pkt;
  logic        beat, pkt_wrap, final_beat;
  logic [STAGES:0] vld_pipe;
  logic [3:0]  flags_q;
  logic [NUM_LANES-1:0] lane_data_bad, lane_keep_bad;
  logic        chk_last, chk_keep, chk_data, chk_hdr;

  assign axis.TREADY = tready_q;
  assign beat       = (state == S_RUN) && axis.TVALID && tready_q;
  assign pkt_wrap   = (exp_pkt == np - 16'd1);
  assign final_beat = beat && axis.TLAST && pkt_wrap && !loop;

  always_comb begin
    state_nxt = state;
    if (!en) state_nxt = S_IDLE;
    else begin
      case (state)
        S_IDLE:  state_nxt = S_RUN;
        S_RUN:   if (final_beat) state_nxt = S_DONE;
        default: state_nxt = state;
      endcase
    end
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    traffic_checker_lane #(.LANE(g), .BYTES(BYTES)) u_lane (
      .word     (axis.TDATA[32*g +: 32]),
      .keep     (axis.TKEEP[4*g +: 4]),
      .last     (axis.TLAST),
      .lfb      (lfb),
      .fill     (fill),
      .data_bad (lane_data_bad[g]),
      .keep_bad (lane_keep_bad[g])
    );
  end

  assign chk_last = axis.TLAST != (exp_flit == nf - 16'd1);
  assign chk_keep = |lane_keep_bad;
  assign chk_data = |lane_data_bad;
  // header lives in the top 4 bytes; only checkable when they are all kept
  assign chk_hdr  = (fill == 2'b01) && (&axis.TKEEP[BYTES-1 -: 4]) &&
                    ((axis.TDATA[WIDTH-1 -: 16] != exp_pkt) ||
                     (axis.TDATA[WIDTH-17 -: 16] != exp_flit));

  function automatic logic [15:0] sat_inc(input logic [15:0] c, input logic hit);
    return (hit && (c != 16'hFFFF)) ? c + 16'd1 : c;
  endfunction

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      state      <= S_IDLE;
      tready_q   <= 1'b0;
      lfsr       <= LFSR_SEED;
      exp_flit   <= '0;
      exp_pkt    <= '0;
      flits_rx   <= '0;
      packets_rx <= '0;
      vld_pipe   <= '0;
      flags_q    <= '0;
      err_last   <= '0;
      err_keep   <= '0;
      err_data   <= '0;
      err_hdr    <= '0;
      err_any    <= 1'b0;
      done       <= 1'b0;
    end else begin
      state <= state_nxt;
      // ready only while staying in RUN, so the final beat closes the stream
      tready_q <= (state == S_RUN) && (state_nxt == S_RUN) && (!bp_en || lfsr[0]);
      if (state == S_RUN)
        lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      else if (state == S_IDLE)
        lfsr <= LFSR_SEED;

      if (beat) begin
        flits_rx <= flits_rx + 32'd1;
        if (axis.TLAST) begin
          packets_rx <= packets_rx + 32'd1;
          exp_flit   <= '0;
          exp_pkt    <= pkt_wrap ? 16'd0 : exp_pkt + 16'd1;
        end else begin
          exp_flit <= exp_flit + 16'd1;
        end
      end

      vld_pipe[0] <= beat;
      flags_q     <= {chk_last, chk_keep, chk_data, chk_hdr};

      if (vld_pipe[STAGES]) begin
        err_last <= sat_inc(err_last, flags_q[3]);
        err_keep <= sat_inc(err_keep, flags_q[2]);
        err_data <= sat_inc(err_data, flags_q[1]);
        err_hdr  <= sat_inc(err_hdr,  flags_q[0]);
        err_any  <= err_any | (|flags_q);
      end
      done <= (state == S_DONE);
    end
  end
endmodule

// File: tb/tb_traffic_checker.sv
// Bench for traffic_checker: directed generator-like stimulus, a per-cycle
// behavioural model of the checker's outputs, and hand-computed end-of-run values.
module tb_traffic_checker;
  localparam int W     = 512;
  localparam int BYTES = W / 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] mode = '0, num_packets = '0, num_flits = '0, last_flit_bytes = '0;
  logic [31:0] flits_rx, packets_rx;
  logic [15:0] err_last, err_keep, err_data, err_hdr;
  logic        err_any, done;

  traffic_checker_if #(.WIDTH(W)) axis ();

  traffic_checker #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .mode(mode), .num_packets(num_packets),
    .num_flits(num_flits), .last_flit_bytes(last_flit_bytes), .axis(axis),
    .flits_rx(flits_rx), .packets_rx(packets_rx), .err_last(err_last),
    .err_keep(err_keep), .err_data(err_data), .err_hdr(err_hdr),
    .err_any(err_any), .done(done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  bit cmp_en = 0;

  // sender (generator stand-in) settings and fault injection
  int s_nf = 1, s_lfb = 64, inj_p = -1, inj_f = -1, flip_p = -1, flip_f = -1, flip_b = 0;
  logic [1:0] s_fill = 2'b00;
  bit s_ones = 0;

  // ---------------- behavioural model ----------------
  int          m_state = 0;           // 0 idle, 1 run, 2 done
  bit          m_tready = 0, m_any = 0, m_done = 0, m_pv = 0;
  logic [15:0] m_lfsr = 16'hACE1, m_flit = 0, m_pkt = 0;
  logic [31:0] m_flits = 0, m_pkts = 0;
  logic [15:0] m_el = 0, m_ek = 0, m_ed = 0, m_eh = 0;
  logic [3:0]  m_pend = 0;
  bit          tready_s = 0;
  int          m_os;

  function automatic logic [3:0] beat_errors(input logic [W-1:0] d, input logic [BYTES-1:0] k,
                                             input logic l, input logic [15:0] ef, input logic [15:0] ep);
    logic el, ek, ed, eh;
    logic [7:0] want;
    logic [31:0] pat;
    logic [1:0] f;
    pat = 32'hDEADBEEF;
    f = mode[2:1];
    el = (l != (ef == num_flits[15:0] - 16'd1));
    ek = 0; ed = 0; eh = 0;
    for (int i = 0; i < BYTES; i++) begin
      if (k[i] != (!l || ((BYTES - 1 - i) < int'(last_flit_bytes[7:0])))) ek = 1;
      want = (f == 2'b11) ? pat[8*(3 - ((BYTES - 1 - i) % 4)) +: 8] : 8'h00;
      if (k[i] && (f == 2'b00 || f == 2'b11) && d[8*i +: 8] != want) ed = 1;
    end
    if (f == 2'b01 && (&k[BYTES-1 -: 4]) && (d[W-1 -: 16] != ep || d[W-17 -: 16] != ef)) eh = 1;
    return {el, ek, ed, eh};
  endfunction

  function automatic logic [15:0] sat(input logic [15:0] c, input logic hit);
    return (hit && c != 16'hFFFF) ? c + 16'd1 : c;
  endfunction

  always @(posedge clk) begin
    if (rst || !mode[0]) begin
      m_state = 0; m_tready = 0; m_lfsr = 16'hACE1; m_flit = 0; m_pkt = 0;
      m_flits = 0; m_pkts = 0; m_pend = 0; m_pv = 0;
      m_el = 0; m_ek = 0; m_ed = 0; m_eh = 0; m_any = 0; m_done = 0;
    end else begin
      m_os = m_state;
      if (m_pv) begin
        m_el = sat(m_el, m_pend[3]); m_ek = sat(m_ek, m_pend[2]);
        m_ed = sat(m_ed, m_pend[1]); m_eh = sat(m_eh, m_pend[0]);
        m_any = m_any | (|m_pend);
      end
      m_done = (m_os == 2);
      m_pv = (m_os == 1) && axis.TVALID && tready_s;
      if (m_pv) begin
        m_pend = beat_errors(axis.TDATA, axis.TKEEP, axis.TLAST, m_flit, m_pkt);
        m_flits++;
        if (axis.TLAST) begin
          m_pkts++;
          m_flit = 0;
          if (m_pkt == num_packets[15:0] - 16'd1) begin
            m_pkt = 0;
            if (!mode[3]) m_state = 2;
          end else m_pkt++;
        end else m_flit++;
      end
      if (m_os == 0) m_state = 1;
      m_tready = (m_os == 1) && (m_state == 1) && (!mode[4] || m_lfsr[0]);
      if (m_os == 1) m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end
  end

  // one compare of the whole output bundle per cycle
  logic [130:0] got_v, exp_v;
  int toggles = 0;
  bit prev_rdy = 0;
  always @(negedge clk) begin
    tready_s = axis.TREADY;
    if (axis.TREADY != prev_rdy) toggles++;
    prev_rdy = axis.TREADY;
    if (cmp_en) begin
      got_v = {flits_rx, packets_rx, err_last, err_keep, err_data, err_hdr, err_any, done, axis.TREADY};
      exp_v = {m_flits, m_pkts, m_el, m_ek, m_ed, m_eh, m_any, m_done, m_tready};
      n_cmp++;
      if (got_v !== exp_v) begin
        n_bad++;
        $display("FAIL model t=%0t: got %h want %h", $time, got_v, exp_v);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, want);
    end
  endtask

  task automatic build(input int p, input int f, output logic [W-1:0] d,
                       output logic [BYTES-1:0] k, output logic l);
    logic [31:0] pat;
    pat = 32'hDEADBEEF;
    l = (f == s_nf - 1) || (p == inj_p && f == inj_f);
    d = '0;
    for (int i = 0; i < BYTES; i++) begin
      k[i] = (f != s_nf - 1) || ((BYTES - 1 - i) < s_lfb);
      if (s_fill == 2'b11) d[8*i +: 8] = pat[8*(i % 4) +: 8];
    end
    if (s_fill == 2'b01) begin
      d[W-1 -: 16]  = p[15:0];
      d[W-17 -: 16] = f[15:0];
    end
    if (s_ones) d = '1;
    if (p == flip_p && f == flip_f) d[8*flip_b +: 8] = d[8*flip_b +: 8] ^ 8'hFF;
  endtask

  // drive nbeats generator beats; returns after the negedge presenting the final accepted beat
  task automatic send(input int nbeats);
    logic [W-1:0] d;
    logic [BYTES-1:0] k;
    logic l;
    int i, cyc;
    i = 0; cyc = 0;
    while (i < nbeats && cyc < 4 * nbeats + 100) begin
      @(negedge clk);
      build(i / s_nf, i % s_nf, d, k, l);
      axis.TDATA = d; axis.TKEEP = k; axis.TLAST = l; axis.TVALID = 1'b1;
      if (axis.TREADY) i++;
      cyc++;
    end
    chk("send_timeout", i, nbeats);
  endtask

  task automatic start_run(input logic [31:0] m, input int np, input int nf, input int lfb);
    @(negedge clk);
    chk("tready_idle", {31'd0, axis.TREADY}, 0);
    num_packets = np; num_flits = nf; last_flit_bytes = lfb; mode = m;
    @(negedge clk);
    chk("tready_first_run_cycle", {31'd0, axis.TREADY}, 0);
    @(negedge clk);
    chk("tready_rise", {31'd0, axis.TREADY}, 1);
  endtask

  // after the final beat: idle bus, TREADY low next cycle, done one cycle later
  task automatic end_run();
    @(negedge clk);
    axis.TVALID = 1'b0;
    chk("done_k1", {31'd0, done}, 0);
    chk("tready_k1", {31'd0, axis.TREADY}, 0);
    @(negedge clk);
    chk("done_k2", {31'd0, done}, 1);
  endtask

  task automatic stop_run();
    @(negedge clk);
    mode[0] = 1'b0;
    @(negedge clk);
    chk("clr_flits", flits_rx, 0);
    chk("clr_pkts", packets_rx, 0);
    chk("clr_any_done", {30'd0, err_any, done}, 0);
    inj_p = -1; inj_f = -1; flip_p = -1; s_ones = 0;
  endtask

  initial begin
    axis.TDATA = '0; axis.TKEEP = '0; axis.TLAST = 1'b0; axis.TVALID = 1'b0;
    repeat (2) @(posedge clk);
    cmp_en = 1;
    @(negedge clk);
    chk("rst_flits", flits_rx, 0);
    chk("rst_tready_done", {30'd0, axis.TREADY, done}, 0);
    rst = 1'b0;

    // clean run: header fill, 4 packets x 3 flits, 20 bytes in last flit
    s_nf = 3; s_lfb = 20; s_fill = 2'b01;
    start_run(32'h3, 4, 3, 20);
    send(12);
    end_run();
    chk("clean_flits", flits_rx, 12);
    chk("clean_pkts", packets_rx, 4);
    chk("clean_errs", {err_last, err_keep} | {err_data, err_hdr}, 0);
    stop_run();

    // sender one byte short on every last flit
    s_lfb = 19;
    start_run(32'h3, 4, 3, 20);
    send(12);
    end_run();
    chk("keep_err", {16'd0, err_keep}, 4);
    chk("keep_others", {err_last, err_data | err_hdr}, 0);
    chk("keep_any", {31'd0, err_any}, 1);
    stop_run();

    // early TLAST on flit 2 of packet 0; checker resyncs and counts 3 packets
    s_nf = 4; s_lfb = 64; s_fill = 2'b00; inj_p = 0; inj_f = 2;
    start_run(32'h1, 3, 4, 64);
    send(8);
    end_run();
    chk("early_last", {16'd0, err_last}, 2);
    chk("early_pkts", packets_rx, 3);
    chk("early_flits", flits_rx, 8);
    chk("early_data", {16'd0, err_data}, 0);
    stop_run();

    // deadbeef with a kept byte flipped in flit 1
    s_nf = 3; s_lfb = 20; s_fill = 2'b11; flip_p = 0; flip_f = 1; flip_b = 5;
    start_run(32'h7, 2, 3, 20);
    send(6);
    end_run();
    chk("dbf_data", {16'd0, err_data}, 1);
    stop_run();

    // flipped byte outside TKEEP on the last flit
    flip_p = 0; flip_f = 2; flip_b = 0;
    start_run(32'h7, 2, 3, 20);
    send(6);
    end_run();
    chk("dbf_unkept", {16'd0, err_data}, 0);
    chk("dbf_unkept_any", {31'd0, err_any}, 0);
    stop_run();

    // random backpressure, looping, 1000 single-flit packets
    s_nf = 1; s_lfb = 64; s_fill = 2'b00;
    start_run(32'h19, 4, 1, 64);
    toggles = 0;
    send(1000);
    @(negedge clk);
    axis.TVALID = 1'b0;
    chk("bp_pkts", packets_rx, 1000);
    @(negedge clk);
    chk("bp_done", {31'd0, done}, 0);
    chk("bp_any", {31'd0, err_any}, 0);
    chk("bp_toggles", {31'd0, toggles > 10}, 1);
    stop_run();

    // saturate err_data, then reset mid-packet
    s_nf = 4; s_lfb = 64; s_fill = 2'b00; s_ones = 1;
    start_run(32'h9, 4, 4, 64);
    send(70002);
    @(negedge clk);
    chk("sat_data", {16'd0, err_data}, 32'hFFFF);
    chk("sat_flits", flits_rx, 70002);
    rst = 1'b1;
    @(negedge clk);
    axis.TVALID = 1'b0;
    chk("rst_mid_flits", flits_rx, 0);
    chk("rst_mid_data", {16'd0, err_data}, 0);
    chk("rst_mid_tready", {30'd0, axis.TREADY, err_any}, 0);
    rst = 1'b0;
    mode = '0;
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1200000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1);
  end
endmodule
